// File: rtl/pm_trigger_rx.sv
// pm_trigger_rx: TCM-side receiver for the PM trigger link.
// It requests a frame on the BC-phase slot, then deserialises the bit-aligned tt/ta lines.
// Frame format on each line: a start bit '1', then DATA_W data bits MSB first, then an even-parity bit.
// Optional feature: define STAT_CNT_EN to build the saturating status counters.
// When it is undefined, cnt_* are tied to 0.
// Ports:
//   clk320, rst            clock and synchronous active-high reset
//   mt_cou                 BC-phase counter; tcm_req is raised after mt_cou==REQ_SLOT is sampled
//   poll                   single-cycle fetch request; it is ignored while busy
//   tt, ta                 serial time/amplitude lines (idle low)
//   tcm_req, busy          frame request to the PM, and transaction in progress
//   time_word, ampl_word   last received words; they are held until the next word_valid
//   word_valid, parity_err word update pulse, with parity status qualifying it
//   frame_err, timeout_err start bit on only one line, and no start bit within START_TO cycles
//   cnt_ok, cnt_perr, cnt_to  good-frame, parity-error and timeout counters
module pm_trigger_rx #(
    parameter int DATA_W   = 12,
    parameter int REQ_SLOT = 0,
    parameter int START_TO = 16
) (
    input  logic              clk320,
    input  logic              rst,
    input  logic [2:0]        mt_cou,
    input  logic              poll,
    input  logic              tt,
    input  logic              ta,
    output logic              tcm_req,
    output logic              busy,
    output logic [DATA_W-1:0] time_word,
    output logic [DATA_W-1:0] ampl_word,
    output logic              word_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              timeout_err,
    output logic [15:0]       cnt_ok,
    output logic [15:0]       cnt_perr,
    output logic [15:0]       cnt_to
);
    localparam int BW = $clog2(DATA_W);
    localparam int TW = $clog2(START_TO + 1);
    typedef enum logic [2:0] {IDLE, ALIGN, WAIT, DATA, PAR} state_t;
    state_t state, state_n;
    logic [TW-1:0] to_cnt;
    logic [BW-1:0] bit_cnt;
    logic [DATA_W-1:0] tt_sr, ta_sr;
    logic to_hit, to_ev, perr_n;
    // A start bit seen in the last timeout cycle still wins over the timeout.
    assign to_hit = to_cnt == TW'(START_TO - 1);
    assign to_ev = state == WAIT && !tt && !ta && to_hit;
    assign perr_n = (^{tt_sr, tt}) | (^{ta_sr, ta});
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = poll ? ALIGN : IDLE;
            ALIGN:   state_n = mt_cou == 3'(REQ_SLOT) ? WAIT : ALIGN;
            WAIT:    state_n = (tt & ta) ? DATA : ((tt ^ ta) || to_hit) ? IDLE : WAIT;
            DATA:    state_n = bit_cnt == BW'(DATA_W - 1) ? PAR : DATA;
            PAR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk320) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            tcm_req     <= 1'b0;
            to_cnt      <= '0;
            bit_cnt     <= '0;
            tt_sr       <= '0;
            ta_sr       <= '0;
            time_word   <= '0;
            ampl_word   <= '0;
            word_valid  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            busy        <= state_n != IDLE;
            tcm_req     <= state_n == WAIT;
            to_cnt      <= state == WAIT ? to_cnt + 1'b1 : '0;
            bit_cnt     <= state == DATA ? bit_cnt + 1'b1 : '0;
            word_valid  <= state == PAR;
            parity_err  <= state == PAR && perr_n;
            frame_err   <= state == WAIT && (tt ^ ta);
            timeout_err <= to_ev;
            if (state == DATA) begin
                tt_sr <= {tt_sr[DATA_W-2:0], tt};
                ta_sr <= {ta_sr[DATA_W-2:0], ta};
            end
            // Words load even when parity is bad; parity_err flags them.
            if (state == PAR) begin
                time_word <= tt_sr;
                ampl_word <= ta_sr;
            end
        end
    end
`ifdef STAT_CNT_EN
    // The counters update on the same edge as the pulses that they count.
    logic ok_ev, pe_ev;
    assign ok_ev = state == PAR && !perr_n;
    assign pe_ev = state == PAR && perr_n;
    always_ff @(posedge clk320) begin
        if (rst) begin
            cnt_ok   <= '0;
            cnt_perr <= '0;
            cnt_to   <= '0;
        end else begin
            cnt_ok   <= cnt_ok + {15'd0, ok_ev && cnt_ok != 16'hFFFF};
            cnt_perr <= cnt_perr + {15'd0, pe_ev && cnt_perr != 16'hFFFF};
            cnt_to   <= cnt_to + {15'd0, to_ev && cnt_to != 16'hFFFF};
        end
    end
`else
    assign cnt_ok   = '0;
    assign cnt_perr = '0;
    assign cnt_to   = '0;
`endif
endmodule
